mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter placed directly downstream of the single-cycle CPU's data-memory port. It observes the CPU store bus (`aluout`, `data`, `wmem`) and claims stores to two word addresses. Claimed stores push bytes into a TX FIFO, which a serial engine shifts out as 8N1 frames. All other stores pass through to the data RAM via a gated write enable, and the block returns a status word for loads from its status address.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); legal values are ≥ 2.
- `FIFO_DEPTH`, 16: TX FIFO entries; must be a power of 2, ≥ 2.
- `TX_ADDR`, 32'h0000_8000: word address of the TX data register (write-only).
- `STAT_ADDR`, 32'h0000_8001: word address of the status register (read/write).

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  32  CPU store/load word address (CPU `aluout`).
- `wdata`  in  32  CPU store data (CPU `data`).
- `wmem`  in  1  CPU store strobe.
- `dram_we`  out  1  write enable to data RAM = `wmem & ~hit`, where hit = (`addr`==`TX_ADDR`) | (`addr`==`STAT_ADDR`); combinational.
- `rdata`  out  32  equals the status word when `addr`==`STAT_ADDR`, else 0; combinational.
- `txd`  out  1  serial output; idles high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Status word: {28'b0, overflow, busy, full, empty}. Bit 0 empty, bit 1 full, bit 2 busy, bit 3 overflow.
- Push: a store with `wmem`=1 and `addr`==`TX_ADDR` pushes `wdata[7:0]` at the edge. `wdata[31:8]` is ignored.
- Push acceptance: a push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
  - On simultaneous push+pop the count is unchanged.
  - A rejected push discards the data and sets sticky `overflow`.
- Overflow clear: a store to `STAT_ADDR` with `wdata[3]`=1 clears `overflow`. If a rejected push occurs on the same edge, set wins.
- FIFO storage: circular buffer with log2(`FIFO_DEPTH`)-bit pointers and a separate count (0..`FIFO_DEPTH`). Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit; after bit 7 go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Counters: the baud counter counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state/bit transition. The bit index is 3 bits wide.

## Timing
- Reset values: `txd`=1, `busy`=0, overflow=0, count=0, pointers=0, state=IDLE, baud counter=0, shift register=0. `rdata` therefore reads 32'h1 at `STAT_ADDR`.
- Reset mid-frame: on the reset edge the frame aborts, `txd`=1 from that edge, and the FIFO is flushed. Reset has priority over push and pop on the same edge.
- Push latency: push at edge N (FIFO was empty, FSM in IDLE). The pop and START entry occur at edge N+1, so `txd` falls after edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- Status update: `empty`/`full` reflect the registered count and update on the edge after a push or pop.
- `dram_we` and `rdata` have zero latency (combinational from `addr`/`wmem`).

## Test plan
Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=16 for all scenarios.
- **Reset:** assert reset for 2 cycles, then read `STAT_ADDR` -> `rdata`=32'h1, `txd`=1, `busy`=0.
- **Single byte:** store 32'h1234_56A5 to `TX_ADDR` -> `dram_we`=0 that cycle. `txd` then shows a 4-cycle low start bit, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 4 cycles high. `busy` deasserts 41 cycles after the store edge.
- **Back-to-back:** store 0x55 and then 0x0F on consecutive cycles -> the second start bit begins immediately after the first stop bit. Total 80 cycles with `busy` continuously high.
- **Overflow:** 18 stores to `TX_ADDR` on consecutive cycles (bytes 0..17) -> byte 0 is popped, bytes 1..16 fill the FIFO, and byte 17 is dropped. Status then reads full=1, overflow=1, and 17 frames are transmitted (0..16). Storing 32'h8 to `STAT_ADDR` afterwards -> overflow=0.
- **Reset mid-frame:** assert reset during data bit 3 of a frame with 3 bytes queued -> `txd`=1 from the reset edge and status reads 32'h1. No further frames follow.
- **Pass-through:** store to address 32'h10 -> `dram_we`=1, FIFO unchanged, and `rdata`=0 for that address.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the CPU data-memory store bus.
// Claims stores to TX_ADDR/STAT_ADDR, queues bytes in a FIFO and shifts them out LSB first.
module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [31:0] TX_ADDR      = 32'h0000_8000,
   parameter logic [31:0] STAT_ADDR    = 32'h0000_8001
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wmem,
   output logic        dram_we,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            r_state, w_state_nxt;
   logic [BAUD_W-1:0] r_baud, w_baud_nxt;
   logic [2:0]        r_bit, w_bit_nxt;
   logic [7:0]        r_shift, w_shift_nxt;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;

   logic w_hit_tx, w_hit_stat, w_push, w_pop, w_accept;
   logic w_empty, w_full, w_baud_last, w_ovf_clr;

   assign w_hit_tx    = (addr == TX_ADDR);
   assign w_hit_stat  = (addr == STAT_ADDR);
   assign w_push      = wmem & w_hit_tx;
   assign w_ovf_clr   = wmem & w_hit_stat & wdata[3];
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CNT_FULL);
   // A pop on the same edge frees the slot, so a full FIFO can still take a push.
   assign w_accept    = w_push & (~w_full | w_pop);
   assign w_baud_last = (r_baud == BAUD_LAST);

   assign dram_we = wmem & ~(w_hit_tx | w_hit_stat);
   assign busy    = (r_state != S_IDLE);
   assign rdata   = w_hit_stat ? {28'b0, r_ovf, busy, w_full, w_empty} : 32'b0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_accept) r_wptr <= r_wptr + 1'b1;
         if (w_pop)    r_rptr <= r_rptr + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push & ~w_accept) r_ovf <= 1'b1;
         else if (w_ovf_clr)     r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (w_accept) r_mem[r_wptr] <= wdata[7:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rptr];
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_baud_last) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_last) begin
               w_baud_nxt  = '0;
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit == 3'd7) w_state_nxt = S_STOP;
               else               w_bit_nxt   = r_bit + 1'b1;
            end
         end
         S_STOP: begin
            // Chain straight into the next start bit so queued frames have no idle gap.
            if (w_baud_last) begin
               w_baud_nxt = '0;
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = r_mem[r_rptr];
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      case (r_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = r_shift[0];
         default: txd = 1'b1;
      endcase
   end

endmodule
